// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the PPU VRAM access port.
//   - B-bus register offsets (low byte of $21xx) decoded by vram_port
//   - address increment step table selected by VMAIN[1:0]
//   - prefetch FSM state encoding
package ppu_pkg;

  localparam logic [7:0] REG_VMAIN   = 8'h15;
  localparam logic [7:0] REG_VMADDL  = 8'h16;
  localparam logic [7:0] REG_VMADDH  = 8'h17;
  localparam logic [7:0] REG_VMDATAL = 8'h18;
  localparam logic [7:0] REG_VMDATAH = 8'h19;
  localparam logic [7:0] REG_RDVRAML = 8'h39;
  localparam logic [7:0] REG_RDVRAMH = 8'h3A;

  // Entry [n] is the word increment for step code n.
  localparam logic [3:0][7:0] STEP_TABLE = {8'd128, 8'd128, 8'd32, 8'd1};

  function automatic logic [14:0] step_words(input logic [1:0] step);
    return {7'd0, STEP_TABLE[step]};
  endfunction

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_ISSUE,
    PF_CAPTURE
  } pf_state_t;

endpackage

// File: rtl/vram_remap.sv
// vram_remap: combinational address translation selected by VMAIN[3:2].
// Rotates the low 8/9/10 bits of the word address left by 3 so that
// bitplane tile rows land in consecutive words.
//   word_addr : 15-bit CPU-side word address
//   mode      : remap mode (00 = none)
//   eff       : 15-bit effective VRAM word address
module vram_remap
  import ppu_pkg::*;
(
  input  logic [14:0] word_addr,
  input  logic [1:0]  mode,
  output logic [14:0] eff
);

  always_comb begin
    case (mode)
      2'b01:   eff = {word_addr[14:8],  word_addr[4:0], word_addr[7:5]};
      2'b10:   eff = {word_addr[14:9],  word_addr[5:0], word_addr[8:6]};
      2'b11:   eff = {word_addr[14:10], word_addr[6:0], word_addr[9:7]};
      default: eff = word_addr;
    endcase
  end

endmodule

// File: rtl/vram_port.sv
// vram_port: CPU B-bus access to the two 8-bit VRAM banks.
//   clk, reset            : clock, synchronous active-high reset
//   reg_addr/wr/rd/din    : CPU register select, strobes and write data
//   reg_dout              : $39/$3A read data from the prefetch latch
//   blank                 : writes reach VRAM only while high
//   vram_addra/b, wra_n/b, dina/b, douta/b : low/high bank VRAM ports
//   busy                  : prefetch in flight
//
// state      | meaning
// PF_IDLE    | bus shows eff, no read pending
// PF_ISSUE   | both banks addressed with pf_addr for a read
// PF_CAPTURE | bank data valid, latched at end of cycle
module vram_port
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  reg_addr,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  input  logic        blank,
  output logic [14:0] vram_addra,
  output logic [14:0] vram_addrb,
  output logic        vram_wra_n,
  output logic        vram_wrb_n,
  output logic [7:0]  vram_dina,
  output logic [7:0]  vram_dinb,
  input  logic [7:0]  vram_douta,
  input  logic [7:0]  vram_doutb,
  output logic        busy
);

  logic [14:0] word_addr;
  logic [14:0] pf_addr;
  logic [14:0] load_addr;
  logic [14:0] eff;
  logic [14:0] load_eff;
  logic        inc_high;
  logic [1:0]  remap;
  logic [1:0]  step;
  logic [15:0] latch;
  pf_state_t   state;

  logic wr_vmain, wr_addrl, wr_addrh, wr_datal, wr_datah;
  logic rd_trig, do_inc, pf_trig, wra, wrb, issuing;

  assign wr_vmain = reg_wr && (reg_addr == REG_VMAIN);
  assign wr_addrl = reg_wr && (reg_addr == REG_VMADDL);
  assign wr_addrh = reg_wr && (reg_addr == REG_VMADDH);
  assign wr_datal = reg_wr && (reg_addr == REG_VMDATAL);
  assign wr_datah = reg_wr && (reg_addr == REG_VMDATAH);

  // A write strobe masks any simultaneous read strobe.
  assign rd_trig = reg_rd && !reg_wr &&
                   (((reg_addr == REG_RDVRAML) && !inc_high) ||
                    ((reg_addr == REG_RDVRAMH) &&  inc_high));

  // Increment applies even to data writes dropped for lack of blank.
  assign do_inc  = (wr_datal && !inc_high) || (wr_datah && inc_high) || rd_trig;
  assign pf_trig = wr_addrl || wr_addrh || rd_trig;

  assign load_addr = wr_addrl ? {word_addr[14:8], reg_din}
                              : {reg_din[6:0], word_addr[7:0]};

  // Address-load prefetch must use the new address, hence a second remap.
  vram_remap u_remap_cur  (.word_addr(word_addr), .mode(remap), .eff(eff));
  vram_remap u_remap_load (.word_addr(load_addr), .mode(remap), .eff(load_eff));

  always_ff @(posedge clk) begin
    if (reset) begin
      word_addr <= '0;
      pf_addr   <= '0;
      inc_high  <= 1'b0;
      remap     <= '0;
      step      <= '0;
      latch     <= '0;
      state     <= PF_IDLE;
      busy      <= 1'b0;
    end else begin
      if (wr_vmain) begin
        inc_high <= reg_din[7];
        remap    <= reg_din[3:2];
        step     <= reg_din[1:0];
      end

      if (wr_addrl || wr_addrh) word_addr <= load_addr;
      else if (do_inc)          word_addr <= word_addr + step_words(step);

      if (pf_trig) begin
        // Restart abandons whatever read was already under way.
        state   <= PF_ISSUE;
        busy    <= 1'b1;
        pf_addr <= rd_trig ? eff : load_eff;
      end else begin
        case (state)
          PF_ISSUE: begin
            // A data write stole the bus this cycle; issue again.
            if (!(wr_datal || wr_datah)) state <= PF_CAPTURE;
          end
          PF_CAPTURE: begin
            latch <= {vram_doutb, vram_douta};
            state <= PF_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= PF_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wra     = wr_datal && blank && !reset;
  assign wrb     = wr_datah && blank && !reset;
  assign issuing = (state == PF_ISSUE);

  assign vram_wra_n = !wra;
  assign vram_wrb_n = !wrb;
  assign vram_dina  = wra ? reg_din : 8'h00;
  assign vram_dinb  = wrb ? reg_din : 8'h00;

  always_comb begin
    vram_addra = eff;
    vram_addrb = eff;
    if (reset) begin
      vram_addra = '0;
      vram_addrb = '0;
    end else if (issuing) begin
      if (!wra) vram_addra = pf_addr;
      if (!wrb) vram_addrb = pf_addr;
    end
  end

  always_comb begin
    case (reg_addr)
      REG_RDVRAML: reg_dout = latch[7:0];
      REG_RDVRAMH: reg_dout = latch[15:8];
      default:     reg_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_vram_port.sv
module tb_vram_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  reg_addr;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic        blank;
  logic [14:0] vram_addra, vram_addrb;
  logic        vram_wra_n, vram_wrb_n;
  logic [7:0]  vram_dina, vram_dinb;
  logic [7:0]  vram_douta, vram_doutb;
  logic        busy;

  vram_port dut (
    .clk(clk), .reset(reset),
    .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_din(reg_din), .reg_dout(reg_dout), .blank(blank),
    .vram_addra(vram_addra), .vram_addrb(vram_addrb),
    .vram_wra_n(vram_wra_n), .vram_wrb_n(vram_wrb_n),
    .vram_dina(vram_dina), .vram_dinb(vram_dinb),
    .vram_douta(vram_douta), .vram_doutb(vram_doutb),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read VRAM banks: data appears the cycle after the address.
  logic [7:0] mem_a [0:32767];
  logic [7:0] mem_b [0:32767];

  always @(posedge clk) begin
    if (!vram_wra_n) mem_a[vram_addra] <= vram_dina;
    if (!vram_wrb_n) mem_b[vram_addrb] <= vram_dinb;
    vram_douta <= mem_a[vram_addra];
    vram_doutb <= mem_b[vram_addrb];
  end

  typedef struct {
    logic        bank;
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  int         total = 0;
  int         bad = 0;
  int         wr_pulses = 0;

  wr_t         exp_w;
  logic        obs_bank;
  logic [14:0] obs_addr;
  logic [7:0]  obs_data;
  logic [7:0]  exp_r;

  // Scoreboard side: compare every VRAM write pulse and every $39/$3A read.
  always @(negedge clk) begin
    if (!reset) begin
      if (!vram_wra_n || !vram_wrb_n) begin
        wr_pulses++;
        total++;
        assert (wq.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_write observed addr_a=%h addr_b=%h wr_n=%b%b expected no write",
                 vram_addra, vram_addrb, vram_wra_n, vram_wrb_n);
        end
        if (wq.size() > 0) begin
          exp_w    = wq.pop_front();
          obs_bank = vram_wra_n;
          obs_addr = obs_bank ? vram_addrb : vram_addra;
          obs_data = obs_bank ? vram_dinb : vram_dina;
          total++;
          assert ({obs_bank, obs_addr, obs_data} === {exp_w.bank, exp_w.addr, exp_w.data}) else begin
            bad++;
            $error("FAIL vram_write observed bank=%0d addr=%h data=%h expected bank=%0d addr=%h data=%h",
                   obs_bank, obs_addr, obs_data, exp_w.bank, exp_w.addr, exp_w.data);
          end
        end
      end
      if (reg_rd && !reg_wr && (reg_addr == 8'h39 || reg_addr == 8'h3A)) begin
        total++;
        assert (rq.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_read observed addr=%h expected no read", reg_addr);
        end
        if (rq.size() > 0) begin
          exp_r = rq.pop_front();
          total++;
          assert (reg_dout === exp_r) else begin
            bad++;
            $error("FAIL reg_dout observed=%h expected=%h", reg_dout, exp_r);
          end
        end
      end
    end
  end

  function automatic logic [14:0] remap_f(input logic [1:0] m, input logic [14:0] a);
    case (m)
      2'b01:   return {a[14:8],  a[4:0], a[7:5]};
      2'b10:   return {a[14:9],  a[5:0], a[8:6]};
      2'b11:   return {a[14:10], a[6:0], a[9:7]};
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    reg_addr = a;
    reg_din  = d;
    reg_wr   = 1'b1;
    tick();
    reg_wr   = 1'b0;
  endtask

  task automatic wr_data(input logic [7:0] a, input logic [7:0] d, input logic [14:0] exp_eff);
    wr_t e;
    e.bank = (a == 8'h19);
    e.addr = exp_eff;
    e.data = d;
    if (blank) wq.push_back(e);
    wr(a, d);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    rq.push_back(exp);
    reg_addr = a;
    reg_rd   = 1'b1;
    tick();
    reg_rd   = 1'b0;
  endtask

  task automatic set_addr(input logic [14:0] a);
    wr(8'h16, a[7:0]);
    wr(8'h17, {1'b0, a[14:8]});
  endtask

  task automatic busy_cycles(output int n);
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    busy_cycles(n);
    chk(tag, 32'(n < 20), 32'd1);
  endtask

  int nb;
  int pulses0;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[16'h0010] = 8'h66; mem_b[16'h0010] = 8'h55;
    mem_a[16'h0011] = 8'h66; mem_b[16'h0011] = 8'h99;

    reset = 1'b1; reg_addr = 8'h39; reg_wr = 1'b0; reg_rd = 1'b0;
    reg_din = 8'h00; blank = 1'b0;
    tick();
    tick();
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_wr_n",   32'({vram_wra_n, vram_wrb_n}), 32'h3);
    chk("rst_addr",   32'({vram_addra, vram_addrb}), 32'h0);
    chk("rst_din",    32'({vram_dina, vram_dinb}), 32'h0);
    chk("rst_dout",   32'(reg_dout), 32'h0);
    reset = 1'b0;
    tick();

    // Sequential writes, increment on the high byte, during blank.
    blank = 1'b1;
    wr(8'h15, 8'h80);
    set_addr(15'h1234);
    wr_data(8'h18, 8'hAA, 15'h1234);
    wr_data(8'h19, 8'hBB, 15'h1234);
    wait_idle("wait_hi_inc");
    chk("hi_inc_addr", 32'(vram_addra), 32'h1235);
    chk("mem_lo_1234", 32'(mem_a[16'h1234]), 32'hAA);
    chk("mem_hi_1234", 32'(mem_b[16'h1234]), 32'hBB);

    // Same sequence outside blank: nothing written, address still moves.
    blank = 1'b0;
    set_addr(15'h1234);
    pulses0 = wr_pulses;
    wr_data(8'h18, 8'hCC, 15'h1234);
    wr_data(8'h19, 8'hDD, 15'h1234);
    wait_idle("wait_noblank");
    chk("noblank_pulses", 32'(wr_pulses - pulses0), 32'd0);
    chk("noblank_addr", 32'(vram_addra), 32'h1235);
    chk("noblank_mem", 32'({mem_b[16'h1234], mem_a[16'h1234]}), 32'hBBAA);

    // Prefetch and reads.
    wr(8'h15, 8'h00);
    set_addr(15'h0010);
    busy_cycles(nb);
    chk("pf_busy_cycles", 32'(nb), 32'd2);
    chk("idle_addr_0010", 32'(vram_addra), 32'h0010);
    rd(8'h39, 8'h66);
    chk("rd_pf_addr", 32'(vram_addra), 32'h0010);
    chk("rd_pf_busy", 32'(busy), 32'd1);
    wait_idle("wait_rd1");
    chk("rd1_inc_addr", 32'(vram_addra), 32'h0011);
    rd(8'h39, 8'h66);
    chk("rd2_pf_addr", 32'(vram_addrb), 32'h0011);
    wait_idle("wait_rd2");
    rd(8'h3A, 8'h99);
    chk("rd_hi_nobusy", 32'(busy), 32'd0);
    chk("rd_hi_noinc", 32'(vram_addra), 32'h0012);

    // Read and write strobes together: the write decode wins, read ignored.
    reg_addr = 8'h39; reg_din = 8'h5A; reg_wr = 1'b1; reg_rd = 1'b1;
    tick();
    reg_wr = 1'b0; reg_rd = 1'b0;
    chk("rdwr_busy", 32'(busy), 32'd0);
    chk("rdwr_addr", 32'(vram_addra), 32'h0012);

    // Unlisted registers are ignored.
    wr(8'h20, 8'hFF);
    wr(8'h3A, 8'hFF);
    wr(8'h14, 8'hFF);
    chk("unlisted_busy", 32'(busy), 32'd0);
    chk("unlisted_addr", 32'(vram_addra), 32'h0012);

    // Remap mode 01, with a data write landing during ISSUE.
    blank = 1'b1;
    wr(8'h15, 8'h04);
    set_addr(15'h00E5);
    wr_data(8'h18, 8'h5A, remap_f(2'b01, 15'h00E5));
    busy_cycles(nb);
    chk("issue_repeat_busy", 32'(nb), 32'd2);
    chk("remap1_next", 32'(vram_addra), 32'(remap_f(2'b01, 15'h00E6)));

    wr(8'h15, 8'h08);
    set_addr(15'h2C75);
    wait_idle("wait_remap2");
    chk("remap2_eff", 32'(vram_addra), 32'(remap_f(2'b10, 15'h2C75)));
    wr(8'h15, 8'h0C);
    wait_idle("wait_remap3");
    chk("remap3_eff", 32'(vram_addrb), 32'(remap_f(2'b11, 15'h2C75)));

    // Step sizes and wraparound.
    wr(8'h15, 8'h01);
    set_addr(15'h7FF0);
    wait_idle("wait_step32");
    wr_data(8'h18, 8'h11, 15'h7FF0);
    wait_idle("wait_wrap32");
    chk("wrap32_addr", 32'(vram_addra), 32'h0010);

    wr(8'h15, 8'h00);
    set_addr(15'h7FFF);
    wait_idle("wait_step1");
    wr_data(8'h18, 8'h22, 15'h7FFF);
    wait_idle("wait_wrap1");
    chk("wrap1_addr", 32'(vram_addra), 32'h0000);

    wr(8'h15, 8'h02);
    set_addr(15'h0100);
    wait_idle("wait_step128");
    wr_data(8'h18, 8'h33, 15'h0100);
    chk("step128_addr", 32'(vram_addra), 32'h0180);
    wr(8'h15, 8'h03);
    wr_data(8'h18, 8'h44, 15'h0180);
    chk("step128b_addr", 32'(vram_addra), 32'h0200);
    wr_data(8'h19, 8'h55, 15'h0200);
    chk("hi_write_noinc", 32'(vram_addra), 32'h0200);
    wait_idle("wait_step_done");

    // Reset arriving while a capture is pending.
    wr(8'h15, 8'h00);
    set_addr(15'h0010);
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    reg_addr = 8'h18; reg_din = 8'hEE; reg_wr = 1'b1;
    #1;
    chk("inrst_wr_n", 32'({vram_wra_n, vram_wrb_n}), 32'h3);
    chk("inrst_addr", 32'({vram_addra, vram_addrb}), 32'h0);
    chk("inrst_din",  32'({vram_dina, vram_dinb}), 32'h0);
    tick();
    reset = 1'b0; reg_wr = 1'b0; reg_addr = 8'h39;
    #1;
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_lat_lo", 32'(reg_dout), 32'h0);
    tick();
    tick();
    reg_addr = 8'h3A;
    #1;
    chk("postrst_lat_hi", 32'(reg_dout), 32'h0);
    chk("postrst_addr", 32'(vram_addra), 32'h0);
    chk("postrst_busy2", 32'(busy), 32'd0);

    tick();
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
